// File: rtl/bmu_multicycle.sv
// -----------------------------------------------------------------------------
// bmu_multicycle
//
// Iterative bit-manipulation unit that sits beside the single-cycle BMU in the
// execute stage. It runs the ops the combinational unit defers: CLMUL, CLMULH,
// CLMULR, CLZ, CPOP and CTZ. The 5-bit option encoding is shared with the
// combinational unit. Execute control stalls on busy and writes back on done.
//
// Parameters:
//   XLEN            operand/result width (only 32 is supported)
//   BITS_PER_CYCLE  operand bits consumed per RUN cycle (1, 2, 4 or 8)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request pulse, sampled only while busy=0
//   option   in   op code (CLMUL=00001 CLMULH=00010 CLMULR=00011
//                 CLZ=00100 CPOP=00101 CTZ=00110; anything else passes in_x)
//   in_x     in   rs1 operand
//   in_y     in   rs2 operand (CLMUL family only)
//   busy     out  high while in RUN or DONE
//   done     out  one-cycle pulse, result valid
//   result   out  final value, held until the next operation completes
//
// Build option:
//   BMU_MULTICYCLE_EARLY_EXIT_EN  when defined, RUN ends as soon as the
//   remaining work is zero; results are identical to the fixed-latency build.
// -----------------------------------------------------------------------------
module bmu_multicycle #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      option,
    input  logic [XLEN-1:0] in_x,
    input  logic [XLEN-1:0] in_y,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N = XLEN / BITS_PER_CYCLE;

    localparam logic [4:0] OP_CLMUL  = 5'b00001;
    localparam logic [4:0] OP_CLMULH = 5'b00010;
    localparam logic [4:0] OP_CLMULR = 5'b00011;
    localparam logic [4:0] OP_CLZ    = 5'b00100;
    localparam logic [4:0] OP_CPOP   = 5'b00101;
    localparam logic [4:0] OP_CTZ    = 5'b00110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True for the option codes this unit iterates on.
    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_CLMUL, OP_CLMULH, OP_CLMULR,
            OP_CLZ, OP_CPOP, OP_CTZ: op_legal = 1'b1;
            default:                 op_legal = 1'b0;
        endcase
    endfunction

    state_t            state_r;
    logic [4:0]        op_r;
    logic [2*XLEN-1:0] xs_r;      // shifted x (left for CLMUL/CLZ, right otherwise)
    logic [XLEN-1:0]   ys_r;      // y shifted right each step
    logic [2*XLEN-1:0] acc_r;     // carry-less product accumulator
    logic [5:0]        cnt_r;     // bit count for CLZ/CTZ/CPOP
    logic              found_r;   // first 1 already seen (CLZ/CTZ)
    logic [5:0]        step_r;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;

    logic [2*XLEN-1:0] acc_s;
    logic [2*XLEN-1:0] xs_s;
    logic [XLEN-1:0]   ys_s;
    logic [5:0]        cnt_s;
    logic              found_s;
    logic [5:0]        cnt_fin_s;
    logic              last_s;
    logic [XLEN-1:0]   res_s;

    // One RUN step: consume BITS_PER_CYCLE bits of the latched operands.
    always_comb begin
        acc_s   = acc_r;
        xs_s    = xs_r;
        ys_s    = ys_r;
        cnt_s   = cnt_r;
        found_s = found_r;
        case (op_r)
            OP_CLMUL, OP_CLMULH, OP_CLMULR: begin
                // xs_r already carries the shift of earlier steps; j adds the in-chunk offset.
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    if (ys_r[j]) begin
                        acc_s = acc_s ^ (xs_r << j);
                    end else begin
                        acc_s = acc_s;
                    end
                end
                xs_s = xs_r << BITS_PER_CYCLE;
                ys_s = ys_r >> BITS_PER_CYCLE;
            end
            OP_CPOP: begin
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    cnt_s = cnt_s + {5'b00000, xs_r[j]};
                end
                xs_s = xs_r >> BITS_PER_CYCLE;
            end
            OP_CTZ: begin
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    if (found_s) begin
                        cnt_s = cnt_s;
                    end else if (xs_r[j]) begin
                        found_s = 1'b1;
                    end else begin
                        cnt_s = cnt_s + 6'd1;
                    end
                end
                xs_s = xs_r >> BITS_PER_CYCLE;
            end
            OP_CLZ: begin
                // Scan from bit XLEN-1 downward; keep the upper half clear so the
                // remaining-work test only sees unscanned bits.
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    if (found_s) begin
                        cnt_s = cnt_s;
                    end else if (xs_r[XLEN-1-j]) begin
                        found_s = 1'b1;
                    end else begin
                        cnt_s = cnt_s + 6'd1;
                    end
                end
                xs_s = {{XLEN{1'b0}}, (xs_r[XLEN-1:0] << BITS_PER_CYCLE)};
            end
            default: begin
                acc_s = acc_r;
            end
        endcase
    end

`ifdef BMU_MULTICYCLE_EARLY_EXIT_EN
    logic rem_zero_s;

    // Nothing left to contribute after this step.
    always_comb begin
        case (op_r)
            OP_CLMUL, OP_CLMULH, OP_CLMULR: rem_zero_s = (ys_s == {XLEN{1'b0}});
            OP_CPOP:                        rem_zero_s = (xs_s[XLEN-1:0] == {XLEN{1'b0}});
            OP_CTZ, OP_CLZ:                 rem_zero_s = found_s || (xs_s[XLEN-1:0] == {XLEN{1'b0}});
            default:                        rem_zero_s = 1'b0;
        endcase
    end

    // Final RUN step: full count reached or no remaining work.
    always_comb begin
        last_s = (step_r == 6'(N-1)) || rem_zero_s;
    end
`else
    // Final RUN step: full count reached.
    always_comb begin
        last_s = (step_r == 6'(N-1));
    end
`endif

    // Result selection from the post-step values. An unfound 1 means x was zero,
    // which also covers a CLZ/CTZ early exit before all bits were counted.
    always_comb begin
        cnt_fin_s = found_s ? cnt_s : 6'd32;
        case (op_r)
            OP_CLMUL:       res_s = acc_s[XLEN-1:0];
            OP_CLMULH:      res_s = acc_s[2*XLEN-1:XLEN];
            OP_CLMULR:      res_s = acc_s[2*XLEN-2:XLEN-1];
            OP_CPOP:        res_s = {{(XLEN-6){1'b0}}, cnt_s};
            OP_CTZ, OP_CLZ: res_s = {{(XLEN-6){1'b0}}, cnt_fin_s};
            default:        res_s = xs_r[XLEN-1:0];
        endcase
    end

    // Control FSM, operand/accumulator state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= 5'b00000;
            xs_r     <= {(2*XLEN){1'b0}};
            ys_r     <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= 6'd0;
            found_r  <= 1'b0;
            step_r   <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r    <= option;
                        xs_r    <= {{XLEN{1'b0}}, in_x};
                        ys_r    <= in_y;
                        acc_r   <= {(2*XLEN){1'b0}};
                        cnt_r   <= 6'd0;
                        found_r <= 1'b0;
                        step_r  <= 6'd0;
                        busy_r  <= 1'b1;
                        if (op_legal(option)) begin
                            state_r <= ST_RUN;
                        end else begin
                            // Unknown op mirrors the combinational unit: pass rs1 through.
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            result_r <= in_x;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_s;
                    xs_r    <= xs_s;
                    ys_r    <= ys_s;
                    cnt_r   <= cnt_s;
                    found_r <= found_s;
                    step_r  <= step_r + 6'd1;
                    if (last_s) begin
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        result_r <= res_s;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_bmu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_bmu_multicycle
//
// Scoreboard bench for bmu_multicycle. Two instances (1 and 4 bits per cycle)
// share the stimulus; each has its own expectation queue holding result,
// start edge and RUN-cycle latency. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bmu_multicycle;

    localparam logic [4:0] CLMUL  = 5'b00001;
    localparam logic [4:0] CLMULH = 5'b00010;
    localparam logic [4:0] CLMULR = 5'b00011;
    localparam logic [4:0] CLZ    = 5'b00100;
    localparam logic [4:0] CPOP   = 5'b00101;
    localparam logic [4:0] CTZ    = 5'b00110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  option;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1;
    exp_t e4;

    bmu_multicycle #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .option(option),
        .in_x(in_x), .in_y(in_y), .busy(busy1), .done(done1), .result(result1)
    );

    bmu_multicycle #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .option(option),
        .in_x(in_x), .in_y(in_y), .busy(busy4), .done(done4), .result(result4)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference results, computed bit by bit over the whole word.
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] p;
        int          c;
        p = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) p = p ^ ({32'd0, x} << i);
        end
        case (op)
            CLMUL:  return p[31:0];
            CLMULH: return p[63:32];
            CLMULR: return p[62:31];
            CLZ: begin
                c = 32;
                for (int i = 0; i < 32; i++) if (x[i]) c = 31 - i;
                return c;
            end
            CTZ: begin
                c = 32;
                for (int i = 31; i >= 0; i--) if (x[i]) c = i;
                return c;
            end
            CPOP: begin
                c = 0;
                for (int i = 0; i < 32; i++) c += int'(x[i]);
                return c;
            end
            default: return x;
        endcase
    endfunction

    function automatic int msb_of(input logic [31:0] v);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        return m;
    endfunction

    // Number of RUN cycles between start edge and the done cycle (0 for illegal ops).
    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] x,
                                   input logic [31:0] y, input int b);
        if (!(op inside {CLMUL, CLMULH, CLMULR, CLZ, CPOP, CTZ})) return 0;
`ifdef BMU_MULTICYCLE_EARLY_EXIT_EN
        case (op)
            CLMUL, CLMULH, CLMULR: return (y == 32'd0) ? 1 : msb_of(y) / b + 1;
            CPOP:                  return (x == 32'd0) ? 1 : msb_of(x) / b + 1;
            CTZ:                   return (x == 32'd0) ? 1 : int'(ref_res(CTZ, x, y)) / b + 1;
            default:               return (x == 32'd0) ? 1 : int'(ref_res(CLZ, x, y)) / b + 1;
        endcase
`else
        return 32 / b;
`endif
    endfunction

    // Drive one start once both units are idle and queue the expectations.
    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
        int n;
        int t;
        n = 0;
        @(negedge clk);
        while ((busy1 || busy4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy1 || busy4) check("idle_wait", {30'd0, busy1, busy4}, 32'd0);
        start  = 1'b1;
        option = op;
        in_x   = x;
        in_y   = y;
        t      = cyc + 1;
        @(posedge clk);
        q1.push_back('{exp, t, ref_lat(op, x, y, 1)});
        q4.push_back('{exp, t, ref_lat(op, x, y, 4)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_ref(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        issue(op, x, y, ref_res(op, x, y));
    endtask

    // Monitor for the 1-bit-per-cycle unit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy1", {31'd0, busy1}, {31'd0, q1.size() != 0});
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    check("spurious_done1", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("result1", result1, e1.res);
                    check("latency1", cyc - e1.t0, e1.lat);
                end
            end
        end
    end

    // Monitor for the 4-bits-per-cycle unit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy4", {31'd0, busy4}, {31'd0, q4.size() != 0});
            if (done4 === 1'b1) begin
                if (q4.size() == 0) begin
                    check("spurious_done4", 32'd1, 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    check("result4", result4, e4.res);
                    check("latency4", cyc - e4.t0, e4.lat);
                end
            end
        end
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [4:0] ops [7];

    // Stimulus sequence.
    initial begin
        ops = '{CLMUL, CLMULH, CLMULR, CLZ, CPOP, CTZ, 5'b10110};
        rst_n  = 1'b1;
        start  = 1'b0;
        option = 5'd0;
        in_x   = 32'd0;
        in_y   = 32'd0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        check("rst_result1", result1, 32'd0);
        check("rst_busy4", {31'd0, busy4}, 32'd0);
        check("rst_done4", {31'd0, done4}, 32'd0);
        check("rst_result4", result4, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with known answers.
        issue(CLMUL,  32'h0000_0003, 32'h0000_0003, 32'h0000_0005);
        issue(CLMUL,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        issue(CLMULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(CLMULR, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        issue(CLZ,    32'h0001_0000, 32'h0,         32'd15);
        issue(CTZ,    32'h0000_0000, 32'h0,         32'd32);
        issue(CLZ,    32'h0000_0000, 32'h0,         32'd32);
        issue(CPOP,   32'hF0F0_F0F0, 32'h0,         32'd16);
        issue(CPOP,   32'hFFFF_FFFF, 32'h0,         32'd32);
        issue(CLMUL,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF);
        issue(CTZ,    32'h0000_0008, 32'h0,         32'd3);
        issue(CLMUL,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
        issue(CLZ,    32'h8000_0000, 32'h0,         32'd0);
        issue(CTZ,    32'h8000_0000, 32'h0,         32'd31);
        issue(5'b00000, 32'hDEAD_BEEF, 32'h1,       32'hDEAD_BEEF);
        issue(5'b11111, 32'hCAFE_F00D, 32'h2,       32'hCAFE_F00D);

        // Starts while busy, with different operands, must be dropped.
        issue(CPOP, 32'hFFFF_FFFF, 32'h0, 32'd32);
        start  = 1'b1;
        option = CLMUL;
        in_x   = 32'h1234_5678;
        in_y   = 32'h0000_0009;
        repeat (3) @(negedge clk);
        start  = 1'b0;

        // Reset in the middle of RUN: outputs clear at once, no done follows.
        issue(CPOP, 32'hFFFF_FFFF, 32'h0, 32'd32);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        q1.delete();
        q4.delete();
        #1;
        check("midrst_busy1", {31'd0, busy1}, 32'd0);
        check("midrst_done1", {31'd0, done1}, 32'd0);
        check("midrst_result1", result1, 32'd0);
        check("midrst_busy4", {31'd0, busy4}, 32'd0);
        check("midrst_done4", {31'd0, done4}, 32'd0);
        check("midrst_result4", result4, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(CPOP, 32'h0000_0001, 32'h0, 32'd1);

        // Random mix, expectations from the reference model.
        for (int k = 0; k < 20; k++) begin
            issue_ref(ops[$urandom_range(0, 6)],
                      $urandom >> $urandom_range(0, 31),
                      $urandom >> $urandom_range(0, 31));
        end

        // Let the last operations drain.
        repeat (50) @(negedge clk);
        check("drain1", q1.size(), 32'd0);
        check("drain4", q4.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bmu_multicycle.md
Name: bmu_multicycle

Overview:
- Iterative companion to the single-cycle bit-manipulation unit in the execute stage.
- Executes the Zbb/Zbc ops the combinational unit defers: CLMUL, CLMULH, CLMULR, CLZ, CPOP, CTZ.
- Shares the 5-bit option encoding with the combinational unit.
- Execute-stage control stalls the pipeline on busy and writes result back on done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- BITS_PER_CYCLE, 1, operand bits consumed per RUN cycle; legal values 1, 2, 4, 8.
- Base latency is N = XLEN/BITS_PER_CYCLE RUN cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when busy=0.
- option  input  5  op code: CLMUL=00001, CLMULH=00010, CLMULR=00011, CLZ=00100, CPOP=00101, CTZ=00110.
- in_x  input  32  rs1 operand.
- in_y  input  32  rs2 operand; used only by CLMUL*.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  final value; held from done until the next accepted start.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, and all internal registers=0.
- States:
  - IDLE: start=1 latches option, in_x, in_y and clears the accumulator and count. Goes to RUN for a legal option, or DONE directly for an illegal option.
  - RUN: processes BITS_PER_CYCLE bits per cycle; goes to DONE after N cycles.
  - DONE: done=1 for exactly one cycle, result registered, then IDLE.
- start while busy=1 is ignored and not queued. start in IDLE is accepted even if done was high the previous cycle.
- Latency: start sampled at edge T, RUN covers cycles T+1..T+N, done is high in cycle T+N+1. Next start is accepted at edge T+N+2.
- Operands are latched at start; later changes on in_x/in_y have no effect.
- CLMUL family:
  - 64-bit accumulator; each RUN step XORs (x << i) into it for every set bit i of y in the current chunk, with y shifted right per step.
  - CLMUL returns prod[31:0], CLMULH returns prod[63:32], CLMULR returns prod[62:31].
- CPOP: adds the popcount of the low chunk of shifted x; result 0..32.
- CTZ:
  - Scans from LSB and counts zeros until the first 1; further bits are ignored.
  - x=0 returns 32.
- CLZ:
  - Scans from MSB (x shifted left) and counts zeros until the first 1.
  - x=0 returns 32.
- Width rules: counts are 6-bit and zero-extended into result; no overflow is possible.
- Illegal option (anything not listed above): result=in_x, done one cycle after start, matching the combinational unit's default behaviour.
- Reset asserted mid-operation: the operation is abandoned immediately, no done is generated, and all outputs go to their reset values.

Optional Feature:
- Macro: BMU_MULTICYCLE_EARLY_EXIT_EN.
- Defined: RUN exits to DONE at the end of the first step after which the remaining work is zero:
  - CLMUL*: remaining shifted y==0.
  - CPOP: remaining shifted x==0.
  - CTZ/CLZ: first 1 found, or remaining x==0; in the x==0 case the count is completed arithmetically to 32.
  - Minimum latency is 1 RUN cycle; for example, CLMUL with y=0 gives done at T+2.
- Undefined: latency is fixed at N+1 regardless of data.
- Results must be bit-identical in both builds.

Test Plan:
- CLMUL x=3, y=3, BITS_PER_CYCLE=1 -> result=0x00000005, done in cycle T+33 only, busy high for T+1..T+33.
- CLMULH and CLMULR with x=y=0x80000000 -> CLMULH=0x40000000, CLMULR=0x80000000; CLMUL=0x00000000.
- CLZ x=0x00010000 -> 15. CTZ x=0 -> 32. CLZ x=0 -> 32. CPOP x=0xF0F0F0F0 -> 16. CPOP x=0xFFFFFFFF -> 32.
- start re-pulsed while busy with different operands -> ignored; original result is delivered.
  - Back-to-back: start on the cycle after done -> accepted.
- rst_n low in the middle of RUN -> busy, done and result are 0 immediately; no done pulse follows.
  - Next CPOP x=0x1 returns 1.
- With BMU_MULTICYCLE_EARLY_EXIT_EN:
  - CLMUL x=0xFFFFFFFF, y=0x1 -> result 0xFFFFFFFF with done at T+2.
  - CTZ x=0x8 -> 3 with done at T+5.
  - Repeat all cases under BITS_PER_CYCLE=4 and compare against the BITS_PER_CYCLE=1 results.
